mult_ctrl: RTL and testbench
============================

MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 33, accumulator width; operand width N = (WIDTH-1)/2 (16 at default).
REQ-002 SHALL have port: Clk  input  1  rising-edge clock.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: Start  input  1  request a new multiply; sampled only in IDLE.
REQ-005 SHALL have port: Abort  input  1  cancel the operation in progress.
REQ-006 SHALL have port: Lsb  input  1  accumulator bit 0, the current multiplier bit.
REQ-007 SHALL have port: Load  output  1  accumulator load strobe.
REQ-008 SHALL have port: Sh  output  1  accumulator right-shift strobe.
REQ-009 SHALL have port: Ad  output  1  accumulator upper-half add strobe.
REQ-010 SHALL have port: Busy  output  1  high while a multiply is in progress.
REQ-011 SHALL have port: Done  output  1  one-cycle pulse; product valid in accumulator.
REQ-012 SHALL have port: Step  output  ceil(log2(N+1))  count of shifts completed.

Function
REQ-013 SHALL implement states IDLE, LOAD, SHIFT, TEST, DONE.
REQ-014 Transition IDLE->LOAD SHALL occur on a clock edge with Start=1; otherwise the FSM SHALL stay in IDLE.
REQ-015 Transition LOAD->SHIFT SHALL be unconditional; Step SHALL be cleared to 0 on entering LOAD.
REQ-016 SHIFT SHALL increment Step; it SHALL go to DONE when the incremented Step equals N, else to TEST.
REQ-017 Transition TEST->SHIFT SHALL be unconditional.
REQ-018 Transition DONE->IDLE SHALL be unconditional; Start seen in DONE SHALL be ignored.
REQ-019 Load SHALL be 1 only in LOAD; the accumulator performs the bit-0 conditional add itself.
REQ-020 Sh SHALL be 1 only in SHIFT.
REQ-021 Ad SHALL equal Lsb in TEST (Mealy output) and SHALL be 0 in every other state.
REQ-022 Load, Sh and Ad SHALL be mutually exclusive in every cycle.
REQ-023 Busy SHALL be 1 in LOAD, SHIFT and TEST; Done SHALL be 1 only in DONE.
REQ-024 Latency: with Start sampled at edge k, Done SHALL be high in cycle k+2N+1 (33 at N=16).
REQ-025 Sequence SHALL be: LOAD, then N SHIFT and N-1 TEST cycles alternating, starting and ending with SHIFT.
REQ-026 Abort=1 in LOAD, SHIFT or TEST SHALL force IDLE at the next edge, with no Done and Step cleared.
REQ-027 Abort in IDLE or DONE SHALL have no effect.
REQ-028 Abort and Start both high in IDLE: Abort SHALL win and the FSM SHALL stay in IDLE.
REQ-029 Start while Busy SHALL be ignored and not queued.
REQ-030 Step SHALL hold its value in DONE and IDLE until the next LOAD.

Reset
REQ-031 Reset=1 SHALL asynchronously force IDLE and set Step=0.
REQ-032 During and after reset, Load, Sh, Ad, Busy and Done SHALL be 0.
REQ-033 Reset mid-operation SHALL abandon the operation without a Done pulse.
REQ-034 A Start on the first edge after Reset deasserts SHALL be accepted.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE, LOAD, SHIFT, TEST, DONE) and a function deriving N and the Step width from WIDTH.
REQ-036 The step counter SHALL be a sub-module, mult_step_counter, with clear, increment and terminal-count (==N) output.
REQ-037 Outputs SHALL be decoded from the state register with no extra pipeline stage.

Verification
REQ-038 Bench SHALL run multiplier 0x0003 with Lsb modelled by a behavioural ACC: Ad=1 in TEST1 only, Done at cycle k+33, product = 3*multiplicand.
REQ-039 Bench SHALL run multiplier 0x0000: zero Ad pulses, exactly 16 Sh pulses, 1 Load pulse, Done at k+33.
REQ-040 Bench SHALL run multiplier 0xFFFF x 0xFFFF: 15 Ad pulses in TEST cycles, product 0xFFFE0001.
REQ-041 Bench SHALL pulse Start at cycles k+5 and k+20 during a multiply: exactly one Done, at k+33.
REQ-042 Bench SHALL assert Abort in the cycle after the 5th Sh: IDLE next cycle, Busy=0, Step=0, no Done; a new Start then completes normally.
REQ-043 Bench SHALL assert Reset asynchronously mid-TEST: all outputs 0 immediately and no Done; Start on the first edge after release gives Done 33 cycles later.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg: shared state encoding and width helpers for the shift-add multiplier controller
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        TEST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int op_width(input int width);
        return (width - 1) / 2;
    endfunction

    function automatic int step_width(input int width);
        return $clog2(op_width(width) + 1);
    endfunction

endpackage

// File: rtl/mult_step_counter.sv
// mult_step_counter: counts completed shifts and flags the shift that will complete the operand
module mult_step_counter #(
    parameter int N = 16,
    parameter int W = 5
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         tc
);

    // tc looks ahead: it is high when the pending increment brings the count to N
    assign tc = (count + W'(1)) == W'(N);

    // clear wins over increment so an abort during SHIFT leaves the count at zero
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count + W'(1);
    end

endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl: control FSM for a shift-add multiplier sequencing load, shift and add strobes
module mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 33,
    localparam int N = op_width(WIDTH),
    localparam int SW = step_width(WIDTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Abort,
    input  logic          Lsb,
    output logic          Load,
    output logic          Sh,
    output logic          Ad,
    output logic          Busy,
    output logic          Done,
    output logic [SW-1:0] Step
);

    state_t state;
    state_t next;
    logic   tc;
    logic   clr;
    logic   inc;

    // next state: Abort only matters while busy, and DONE always returns to IDLE
    always_comb begin
        next = state == IDLE  ? (Start && !Abort ? LOAD : IDLE)
             : state == DONE  ? IDLE
             : Abort          ? IDLE
             : state == LOAD  ? SHIFT
             : state == SHIFT ? (tc ? DONE : TEST)
             : state == TEST  ? SHIFT
             : IDLE;
    end

    // state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= next;
    end

    // strobes decoded straight from the state; Ad is Mealy on the current multiplier bit
    always_comb begin
        Load = state == LOAD;
        Sh   = state == SHIFT;
        Ad   = state == TEST && Lsb;
        Busy = state == LOAD || state == SHIFT || state == TEST;
        Done = state == DONE;
        clr  = (state == IDLE && Start && !Abort) || (Busy && Abort);
        inc  = state == SHIFT && !Abort;
    end

    mult_step_counter #(.N(N), .W(SW)) u_step (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (clr),
        .inc   (inc),
        .count (Step),
        .tc    (tc)
    );

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: drives mult_ctrl against a behavioural accumulator and scores products and timing
module tb_mult_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic        Lsb;
    logic        Load, Sh, Ad, Busy, Done;
    logic [4:0]  Step;

    logic [32:0] acc = '0;
    logic [15:0] mp = '0;
    logic [15:0] mc = '0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          n_load = 0, n_sh = 0, n_ad = 0, n_done = 0, n_excl = 0, n_aderr = 0;
    int          last_ad_cyc = -1;
    logic [31:0] exp_q[$];

    mult_ctrl #(.WIDTH(33)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Abort (Abort),
        .Lsb   (Lsb),
        .Load  (Load),
        .Sh    (Sh),
        .Ad    (Ad),
        .Busy  (Busy),
        .Done  (Done),
        .Step  (Step)
    );

    always #5 Clk = ~Clk;

    assign Lsb = acc[0];

    // behavioural accumulator: load does the bit-0 add, Ad adds to upper half, Sh shifts right
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (Load)
            acc <= {(mp[0] ? {1'b0, mc} : 17'd0), mp};
        else if (Ad)
            acc <= {acc[32:16] + {1'b0, mc}, acc[15:0]};
        else if (Sh)
            acc <= acc >> 1;
    end

    // strobe monitor sampled mid-cycle
    always @(negedge Clk) begin
        n_load <= n_load + int'(Load);
        n_sh   <= n_sh + int'(Sh);
        n_ad   <= n_ad + int'(Ad);
        n_done <= n_done + int'(Done);
        if (Ad) last_ad_cyc <= cyc;
        if (int'(Load) + int'(Sh) + int'(Ad) > 1) n_excl <= n_excl + 1;
        if ((Busy && !Load && !Sh) ? (Ad !== Lsb) : Ad) n_aderr <= n_aderr + 1;
    end

    task automatic start_op(input logic [15:0] p, input logic [15:0] c, input bit push, output int k);
        mp = p;
        mc = c;
        Start = 1'b1;
        k = cyc;
        if (push) exp_q.push_back(32'(p) * 32'(c));
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge Clk);
            if (Done) begin
                dc = cyc;
                break;
            end
        end
    endtask

    task automatic check_product(input string name);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, acc[31:0]);
        end else begin
            e = exp_q.pop_front();
            if (acc[31:0] !== e) begin
                errors++;
                $display("FAIL %s: product got %h expected %h", name, acc[31:0], e);
            end
        end
    endtask

    task automatic test_reset;
        #1 Reset = 1'b1;
        #1;
        checks++;
        if ({Load, Sh, Ad, Busy, Done} !== 5'b0 || Step !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b step %0d expected 00000 step 0", {Load, Sh, Ad, Busy, Done}, Step);
        end
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if ({Load, Sh, Ad, Busy, Done} !== 5'b0) begin
            errors++;
            $display("FAIL after_reset_idle: got %b expected 00000", {Load, Sh, Ad, Busy, Done});
        end
    endtask

    task automatic test_mult3;
        int k, dc, s_sh, s_ad;
        s_sh = n_sh;
        s_ad = n_ad;
        start_op(16'h0003, 16'h1234, 1'b1, k);
        checks++;
        if (Load !== 1'b1 || Busy !== 1'b1 || Step !== 5'd0) begin
            errors++;
            $display("FAIL m3_load: load %b busy %b step %0d expected 1 1 0", Load, Busy, Step);
        end
        wait_done(dc);
        checks++;
        if (dc !== k + 33) begin
            errors++;
            $display("FAIL m3_latency: done at %0d expected %0d", dc, k + 33);
        end
        checks++;
        if (Step !== 5'd16 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL m3_done_step: step %0d busy %b expected 16 0", Step, Busy);
        end
        check_product("m3_product");
        @(negedge Clk);
        checks++;
        if (Step !== 5'd16 || Done !== 1'b0) begin
            errors++;
            $display("FAIL m3_idle_hold: step %0d done %b expected 16 0", Step, Done);
        end
        checks++;
        if (n_ad - s_ad !== 1 || last_ad_cyc !== k + 3) begin
            errors++;
            $display("FAIL m3_ad: %0d pulses last at %0d expected 1 at %0d", n_ad - s_ad, last_ad_cyc, k + 3);
        end
        checks++;
        if (n_sh - s_sh !== 16) begin
            errors++;
            $display("FAIL m3_sh: %0d pulses expected 16", n_sh - s_sh);
        end
    endtask

    task automatic test_zero;
        int k, dc, s_sh, s_ad, s_ld;
        s_sh = n_sh;
        s_ad = n_ad;
        s_ld = n_load;
        start_op(16'h0000, 16'hABCD, 1'b1, k);
        wait_done(dc);
        checks++;
        if (dc !== k + 33) begin
            errors++;
            $display("FAIL zero_latency: done at %0d expected %0d", dc, k + 33);
        end
        check_product("zero_product");
        @(negedge Clk);
        checks++;
        if (n_ad - s_ad !== 0 || n_sh - s_sh !== 16 || n_load - s_ld !== 1) begin
            errors++;
            $display("FAIL zero_counts: ad %0d sh %0d load %0d expected 0 16 1", n_ad - s_ad, n_sh - s_sh, n_load - s_ld);
        end
    endtask

    task automatic test_ffff;
        int k, dc, s_ad;
        s_ad = n_ad;
        start_op(16'hFFFF, 16'hFFFF, 1'b1, k);
        wait_done(dc);
        checks++;
        if (dc !== k + 33) begin
            errors++;
            $display("FAIL ffff_latency: done at %0d expected %0d", dc, k + 33);
        end
        checks++;
        if (acc[31:0] !== 32'hFFFE0001) begin
            errors++;
            $display("FAIL ffff_literal: product got %h expected fffe0001", acc[31:0]);
        end
        check_product("ffff_product");
        @(negedge Clk);
        checks++;
        if (n_ad - s_ad !== 15) begin
            errors++;
            $display("FAIL ffff_ad: %0d pulses expected 15", n_ad - s_ad);
        end
    endtask

    task automatic test_back_to_back;
        int k, dc, s_dn;
        s_dn = n_done;
        dc = -1;
        start_op(16'h0105, 16'h0203, 1'b1, k);
        while (cyc < k + 60) begin
            @(negedge Clk);
            Start = (cyc == k + 5 || cyc == k + 20);
            if (Done && dc < 0) begin
                dc = cyc;
                check_product("busy_start_product");
            end
        end
        Start = 1'b0;
        checks++;
        if (dc !== k + 33) begin
            errors++;
            $display("FAIL busy_start_latency: done at %0d expected %0d", dc, k + 33);
        end
        checks++;
        if (n_done - s_dn !== 1) begin
            errors++;
            $display("FAIL busy_start_count: %0d done pulses expected 1", n_done - s_dn);
        end
    endtask

    task automatic test_abort;
        int k, dc, s, s_dn;
        s_dn = n_done;
        s = 0;
        start_op(16'h00FF, 16'h0011, 1'b0, k);
        for (int i = 0; i < 20 && s < 5; i++) begin
            @(negedge Clk);
            if (Sh) s++;
        end
        @(negedge Clk);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Step !== 5'd0 || Done !== 1'b0 || Load !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy %b step %0d done %b load %b expected 0 0 0 0", Busy, Step, Done, Load);
        end
        repeat (40) @(negedge Clk);
        checks++;
        if (n_done - s_dn !== 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d done pulses expected 0", n_done - s_dn);
        end
        Start = 1'b1;
        Abort = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Abort = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Load !== 1'b0) begin
            errors++;
            $display("FAIL abort_start_idle: busy %b load %b expected 0 0", Busy, Load);
        end
        start_op(16'h0005, 16'h0007, 1'b1, k);
        wait_done(dc);
        checks++;
        if (dc !== k + 33) begin
            errors++;
            $display("FAIL abort_restart_latency: done at %0d expected %0d", dc, k + 33);
        end
        check_product("abort_restart_product");
        @(negedge Clk);
    endtask

    task automatic test_async_reset;
        int k, dc, s_dn;
        bit found;
        found = 1'b0;
        s_dn = n_done;
        start_op(16'hA5A5, 16'h5A5A, 1'b0, k);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge Clk);
            found = Busy && !Load && !Sh && cyc >= k + 6;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_find_test: TEST state not reached, busy %b", Busy);
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({Load, Sh, Ad, Busy, Done} !== 5'b0 || Step !== 5'd0) begin
            errors++;
            $display("FAIL rst_async: got %b step %0d expected 00000 step 0", {Load, Sh, Ad, Busy, Done}, Step);
        end
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        start_op(16'h1357, 16'h2468, 1'b1, k);
        wait_done(dc);
        checks++;
        if (dc !== k + 33) begin
            errors++;
            $display("FAIL rst_restart_latency: done at %0d expected %0d", dc, k + 33);
        end
        checks++;
        if (n_done - s_dn !== 0) begin
            errors++;
            $display("FAIL rst_no_done: %0d done pulses before restart done expected 0", n_done - s_dn);
        end
        check_product("rst_restart_product");
        @(negedge Clk);
    endtask

    task automatic test_strobe_rules;
        checks++;
        if (n_excl !== 0 || n_aderr !== 0) begin
            errors++;
            $display("FAIL strobe_rules: overlap %0d ad_errors %0d expected 0 0", n_excl, n_aderr);
        end
    endtask

    initial begin
        test_reset;
        test_mult3;
        test_zero;
        test_ffff;
        test_back_to_back;
        test_abort;
        test_async_reset;
        test_strobe_rules;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
